// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default geometry for the memory-bus arbiter and its address decoder.
// Pure declarations: no latency, no backpressure.
package mem_bus_arbiter_pkg;

    localparam int          DEF_ADDR_WIDTH = 16;
    localparam int          DEF_DATA_WIDTH = 8;
    localparam logic [15:0] DEF_RAM_SIZE   = 16'h1000;
    localparam logic [15:0] DEF_MMIO_BASE  = 16'hE000;
    localparam logic [15:0] DEF_ROM_BASE   = 16'hF000;
    localparam int          DEF_HOLD_MAX   = 4;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACCESS,
        BUS_RESP
    } bus_state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_ROM,
        REG_NONE
    } mem_region_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory-side and status signals of the shared bus; master = arbiter view.
// No logic: latency and backpressure are defined by the arbiter (req held until ack).
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;

    logic                  ldr_req;
    logic                  ldr_we;
    logic [ADDR_WIDTH-1:0] ldr_addr;
    logic [DATA_WIDTH-1:0] ldr_wdata;
    logic [DATA_WIDTH-1:0] ldr_rdata;
    logic                  ldr_ack;
    logic                  ldr_hold;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  ram_ce;
    logic                  rom_ce;
    logic                  mmio_ce;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] rom_rdata;
    logic [DATA_WIDTH-1:0] mmio_rdata;

    logic                  bus_err;
    logic                  grant_owner;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_hold,
        input  ram_rdata, rom_rdata, mmio_rdata,
        output cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        output mem_addr, mem_wdata, mem_we, ram_ce, rom_ce, mmio_ce,
        output bus_err, grant_owner
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_hold,
        output ram_rdata, rom_rdata, mmio_rdata,
        input  cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        input  mem_addr, mem_wdata, mem_we, ram_ce, rom_ce, mmio_ce,
        input  bus_err, grant_owner
    );

endinterface

// File: rtl/mem_bus_arbiter_addr_decoder.sv
// Maps a bus address to its memory region (RAM / MMIO / ROM / unmapped).
// Purely combinational, zero latency, no backpressure.
module mem_bus_arbiter_addr_decoder
    import mem_bus_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RAM_SIZE   = DEF_RAM_SIZE,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = DEF_MMIO_BASE,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = DEF_ROM_BASE
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output mem_region_t           o_region
);

    always_comb begin
        o_region = REG_NONE;
        if (i_addr < RAM_SIZE) begin
            o_region = REG_RAM;
        end else if (i_addr >= ROM_BASE) begin
            o_region = REG_ROM;
        end else if (i_addr >= MMIO_BASE) begin
            o_region = REG_MMIO;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates CPU and loader onto RAM/ROM/MMIO: IDLE->ACCESS->RESP, ack 2 cycles after req.
// Round-robin with bounded loader burst lock; requesters hold req until their ack.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RAM_SIZE   = DEF_RAM_SIZE,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = DEF_MMIO_BASE,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = DEF_ROM_BASE,
    parameter int                    HOLD_MAX   = DEF_HOLD_MAX
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mem_bus_arbiter_if.master  io_bus
);

    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    bus_state_t            r_state;
    bus_state_t            w_state_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_nxt;
    logic                  r_owner;
    logic                  w_grant_ldr;
    logic                  w_any_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_we;
    logic                  r_bus_err;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;
    logic [DATA_WIDTH-1:0] w_resp_data;
    logic                  w_access;
    logic                  w_cpu_ack;
    logic                  w_ldr_ack;
    mem_region_t           w_region;

    mem_bus_arbiter_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_SIZE   (RAM_SIZE),
        .MMIO_BASE  (MMIO_BASE),
        .ROM_BASE   (ROM_BASE)
    ) u_addr_decoder (
        .i_addr   (r_mem_addr),
        .o_region (w_region)
    );

    assign w_any_req = io_bus.cpu_req || io_bus.ldr_req;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_grant_ldr = 1'b0;
        case (r_state)
            BUS_IDLE: begin
                if (!io_bus.cpu_req || !io_bus.ldr_hold) begin
                    w_hold_nxt = '0;
                end
                if (io_bus.cpu_req && io_bus.ldr_req) begin
                    if (io_bus.ldr_hold && (r_hold_cnt < HOLD_W'(HOLD_MAX))) begin
                        w_grant_ldr = 1'b1;
                        w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                    end else if (io_bus.ldr_hold) begin
                        // Lock budget spent: the waiting CPU gets exactly one slot.
                        w_grant_ldr = 1'b0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_grant_ldr = ~r_owner;
                    end
                end else begin
                    w_grant_ldr = io_bus.ldr_req;
                end
                if (w_any_req) begin
                    w_state_nxt = BUS_ACCESS;
                end
            end
            BUS_ACCESS: w_state_nxt = BUS_RESP;
            BUS_RESP:   w_state_nxt = BUS_IDLE;
            default:    w_state_nxt = BUS_IDLE;
        endcase
    end

    assign w_access  = (r_state == BUS_ACCESS);
    assign w_cpu_ack = (r_state == BUS_RESP) && !r_owner;
    assign w_ldr_ack = (r_state == BUS_RESP) &&  r_owner;

    // Write responses and unmapped reads return zero.
    always_comb begin
        w_resp_data = '0;
        if (!r_mem_we) begin
            case (w_region)
                REG_RAM:  w_resp_data = io_bus.ram_rdata;
                REG_MMIO: w_resp_data = io_bus.mmio_rdata;
                REG_ROM:  w_resp_data = io_bus.rom_rdata;
                default:  w_resp_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= BUS_IDLE;
            r_hold_cnt  <= '0;
            r_owner     <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            if ((r_state == BUS_IDLE) && w_any_req) begin
                r_owner     <= w_grant_ldr;
                r_mem_addr  <= w_grant_ldr ? io_bus.ldr_addr  : io_bus.cpu_addr;
                r_mem_wdata <= w_grant_ldr ? io_bus.ldr_wdata : io_bus.cpu_wdata;
                r_mem_we    <= w_grant_ldr ? io_bus.ldr_we    : io_bus.cpu_we;
            end
            if (w_access && ((w_region == REG_NONE) || ((w_region == REG_ROM) && r_mem_we))) begin
                r_bus_err <= 1'b1;
            end
            if (w_cpu_ack) begin
                r_cpu_rdata <= w_resp_data;
            end
            if (w_ldr_ack) begin
                r_ldr_rdata <= w_resp_data;
            end
        end
    end

    assign io_bus.mem_addr    = r_mem_addr;
    assign io_bus.mem_wdata   = r_mem_wdata;
    assign io_bus.ram_ce      = w_access && (w_region == REG_RAM);
    assign io_bus.mmio_ce     = w_access && (w_region == REG_MMIO);
    assign io_bus.rom_ce      = w_access && (w_region == REG_ROM);
    // ROM writes still strobe rom_ce but never mem_we.
    assign io_bus.mem_we      = w_access && r_mem_we && ((w_region == REG_RAM) || (w_region == REG_MMIO));
    assign io_bus.cpu_ack     = w_cpu_ack;
    assign io_bus.ldr_ack     = w_ldr_ack;
    assign io_bus.cpu_rdata   = w_cpu_ack ? w_resp_data : r_cpu_rdata;
    assign io_bus.ldr_rdata   = w_ldr_ack ? w_resp_data : r_ldr_rdata;
    assign io_bus.bus_err     = r_bus_err;
    assign io_bus.grant_owner = r_owner;

endmodule
